// File: rtl/mem_req_arbiter.sv
// Two-master memory request arbiter: fetch vs MEM stage onto one bus.
// One transaction outstanding; MEM wins unless fetch has been starved.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_in,
    input  logic [31:0] inst_addr_in,
    output logic        inst_addr_ok_out,
    output logic        inst_data_ok_out,
    output logic [31:0] inst_rdata_out,
    input  logic        data_req_in,
    input  logic        data_wr_in,
    input  logic [3:0]  data_wstrb_in,
    input  logic [31:0] data_addr_in,
    input  logic [31:0] data_wdata_in,
    output logic        data_addr_ok_out,
    output logic        data_data_ok_out,
    output logic [31:0] data_rdata_out,
    output logic        bus_req_out,
    output logic        bus_wr_out,
    output logic [3:0]  bus_wstrb_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_addr_ok_in,
    input  logic        bus_data_ok_in,
    input  logic [31:0] bus_rdata_in
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          owner_inst;
    logic [31:0]   addr_q;
    logic          wr_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   wdata_q;
    logic          grant_inst;
    logic          grant_data;
    logic          done;

    // Grants and completion are suppressed while reset is held.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (inst_req_in && (starve_cnt == LIMIT || !data_req_in))
                grant_inst = 1'b1;
            else if (data_req_in)
                grant_data = 1'b1;
        end
        done = (state == S_WAIT) && bus_data_ok_in && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (grant_inst || grant_data) state_nxt = S_ADDR;
            S_ADDR: if (bus_addr_ok_in) state_nxt = S_WAIT;
            S_WAIT: if (bus_data_ok_in) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_inst <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end else if (grant_inst) begin
            owner_inst <= 1'b1;
            addr_q     <= inst_addr_in;
            wr_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end else if (grant_data) begin
            owner_inst <= 1'b0;
            addr_q     <= data_addr_in;
            wr_q       <= data_wr_in;
            wstrb_q    <= data_wstrb_in;
            wdata_q    <= data_wdata_in;
        end
    end

    // Counts MEM grants that passed over a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_inst)
            starve_cnt <= '0;
        else if (grant_data) begin
            if (!inst_req_in)
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_comb begin
        inst_addr_ok_out = grant_inst;
        data_addr_ok_out = grant_data;
        inst_data_ok_out = done && owner_inst;
        data_data_ok_out = done && !owner_inst;
        inst_rdata_out   = inst_data_ok_out ? bus_rdata_in : 32'h0;
        data_rdata_out   = data_data_ok_out ? bus_rdata_in : 32'h0;
        bus_req_out      = (state == S_ADDR) && !rst;
        bus_wr_out       = wr_q;
        bus_wstrb_out    = wstrb_q;
        bus_addr_out     = addr_q;
        bus_wdata_out    = wdata_q;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: load, starvation order, store,
// fetch/data overlap and mid-transaction reset.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_in;
    logic [31:0] inst_addr_in;
    logic        inst_addr_ok_out;
    logic        inst_data_ok_out;
    logic [31:0] inst_rdata_out;
    logic        data_req_in;
    logic        data_wr_in;
    logic [3:0]  data_wstrb_in;
    logic [31:0] data_addr_in;
    logic [31:0] data_wdata_in;
    logic        data_addr_ok_out;
    logic        data_data_ok_out;
    logic [31:0] data_rdata_out;
    logic        bus_req_out;
    logic        bus_wr_out;
    logic [3:0]  bus_wstrb_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic        bus_addr_ok_in;
    logic        bus_data_ok_in;
    logic [31:0] bus_rdata_in;

    int n_cmp = 0;
    int n_err = 0;

    mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_req_in      (inst_req_in),
        .inst_addr_in     (inst_addr_in),
        .inst_addr_ok_out (inst_addr_ok_out),
        .inst_data_ok_out (inst_data_ok_out),
        .inst_rdata_out   (inst_rdata_out),
        .data_req_in      (data_req_in),
        .data_wr_in       (data_wr_in),
        .data_wstrb_in    (data_wstrb_in),
        .data_addr_in     (data_addr_in),
        .data_wdata_in    (data_wdata_in),
        .data_addr_ok_out (data_addr_ok_out),
        .data_data_ok_out (data_data_ok_out),
        .data_rdata_out   (data_rdata_out),
        .bus_req_out      (bus_req_out),
        .bus_wr_out       (bus_wr_out),
        .bus_wstrb_out    (bus_wstrb_out),
        .bus_addr_out     (bus_addr_out),
        .bus_wdata_out    (bus_wdata_out),
        .bus_addr_ok_in   (bus_addr_ok_in),
        .bus_data_ok_in   (bus_data_ok_in),
        .bus_rdata_in     (bus_rdata_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_iaok"}, 32'(inst_addr_ok_out), 0);
        chk({tag, "_daok"}, 32'(data_addr_ok_out), 0);
        chk({tag, "_idok"}, 32'(inst_data_ok_out), 0);
        chk({tag, "_ddok"}, 32'(data_data_ok_out), 0);
        chk({tag, "_ird"}, inst_rdata_out, 0);
        chk({tag, "_drd"}, data_rdata_out, 0);
        chk({tag, "_breq"}, 32'(bus_req_out), 0);
        chk({tag, "_bwr"}, 32'(bus_wr_out), 0);
        chk({tag, "_bstb"}, 32'(bus_wstrb_out), 0);
        chk({tag, "_badr"}, bus_addr_out, 0);
        chk({tag, "_bwd"}, bus_wdata_out, 0);
    endtask

    // One full transaction with bus ok lines tied high; starts in IDLE.
    task automatic txn(input bit exp_i, input string tag);
        @(negedge clk);
        chk({tag, "_iaok"}, 32'(inst_addr_ok_out), 32'(exp_i));
        chk({tag, "_daok"}, 32'(data_addr_ok_out), 32'(!exp_i));
        chk({tag, "_breq0"}, 32'(bus_req_out), 0);
        @(negedge clk);
        chk({tag, "_breq1"}, 32'(bus_req_out), 1);
        chk({tag, "_badr"}, bus_addr_out,
            exp_i ? inst_addr_in : data_addr_in);
        @(negedge clk);
        chk({tag, "_idok"}, 32'(inst_data_ok_out), 32'(exp_i));
        chk({tag, "_ddok"}, 32'(data_data_ok_out), 32'(!exp_i));
        chk({tag, "_ird"}, inst_rdata_out, exp_i ? bus_rdata_in : 0);
        chk({tag, "_drd"}, data_rdata_out, exp_i ? 0 : bus_rdata_in);
        chk({tag, "_breq2"}, 32'(bus_req_out), 0);
    endtask

    initial begin
        rst            = 1'b1;
        inst_req_in    = 1'b1;
        inst_addr_in   = 32'h0000_0100;
        data_req_in    = 1'b1;
        data_wr_in     = 1'b0;
        data_wstrb_in  = 4'h0;
        data_addr_in   = 32'h1FC0_0010;
        data_wdata_in  = 32'h0;
        bus_addr_ok_in = 1'b1;
        bus_data_ok_in = 1'b1;
        bus_rdata_in   = 32'hDEAD_BEEF;

        repeat (2) begin
            @(negedge clk);
            chk_quiet("rst");
        end

        // Single load right out of reset
        @(posedge clk); #1;
        rst         = 1'b0;
        inst_req_in = 1'b0;
        txn(1'b0, "load");

        // Fetch idle: counter must stay at zero
        data_addr_in = 32'h0000_0200;
        bus_rdata_in = 32'h1234_5678;
        for (int i = 0; i < 10; i++) txn(1'b0, "noinst");

        // Both held: D D D D I D
        @(posedge clk); #1;
        inst_req_in = 1'b1;
        for (int i = 0; i < 6; i++) txn(i == 4, $sformatf("both%0d", i));

        // Store with delayed address acceptance
        @(posedge clk); #1;
        inst_req_in    = 1'b0;
        data_req_in    = 1'b1;
        data_wr_in     = 1'b1;
        data_wstrb_in  = 4'b0011;
        data_addr_in   = 32'h0000_0080;
        data_wdata_in  = 32'hCAFE_F00D;
        bus_addr_ok_in = 1'b0;
        bus_data_ok_in = 1'b0;
        bus_rdata_in   = 32'h5555_AAAA;
        @(negedge clk);
        chk("st_daok", 32'(data_addr_ok_out), 1);
        chk("st_breq0", 32'(bus_req_out), 0);
        @(posedge clk); #1;
        data_req_in   = 1'b0;
        data_wr_in    = 1'b0;
        data_wstrb_in = 4'h0;
        data_addr_in  = 32'h0;
        data_wdata_in = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_addr_ok_in = 1'b1;
            @(negedge clk);
            chk($sformatf("st_breq%0d", i), 32'(bus_req_out), 1);
            chk($sformatf("st_wr%0d", i), 32'(bus_wr_out), 1);
            chk($sformatf("st_stb%0d", i), 32'(bus_wstrb_out), 32'h3);
            chk($sformatf("st_wd%0d", i), bus_wdata_out, 32'hCAFE_F00D);
            chk($sformatf("st_ad%0d", i), bus_addr_out, 32'h80);
            chk($sformatf("st_dok%0d", i), 32'(data_data_ok_out), 0);
            @(posedge clk); #1;
        end
        bus_addr_ok_in = 1'b0;
        @(negedge clk);
        chk("st_wait_breq", 32'(bus_req_out), 0);
        chk("st_wait_dok", 32'(data_data_ok_out), 0);
        @(posedge clk); #1;
        bus_data_ok_in = 1'b1;
        @(negedge clk);
        chk("st_dok", 32'(data_data_ok_out), 1);
        chk("st_drd", data_rdata_out, 32'h5555_AAAA);
        chk("st_idok", 32'(inst_data_ok_out), 0);
        @(posedge clk); #1;
        bus_data_ok_in = 1'b0;
        @(negedge clk);
        chk("st_dok_once", 32'(data_data_ok_out), 0);
        chk("st_wd_hold", bus_wdata_out, 32'hCAFE_F00D);
        chk("st_wr_hold", 32'(bus_wr_out), 1);

        // Fetch outstanding while MEM request rises
        @(posedge clk); #1;
        inst_req_in    = 1'b1;
        inst_addr_in   = 32'h0000_0400;
        bus_addr_ok_in = 1'b1;
        @(negedge clk);
        chk("f_iaok", 32'(inst_addr_ok_out), 1);
        chk("f_daok", 32'(data_addr_ok_out), 0);
        @(posedge clk); #1;
        inst_req_in = 1'b0;
        @(negedge clk);
        chk("f_breq", 32'(bus_req_out), 1);
        chk("f_badr", bus_addr_out, 32'h400);
        chk("f_bwr", 32'(bus_wr_out), 0);
        chk("f_bstb", 32'(bus_wstrb_out), 0);
        chk("f_bwd", bus_wdata_out, 0);
        @(posedge clk); #1;
        data_req_in  = 1'b1;
        data_addr_in = 32'h0000_0300;
        @(negedge clk);
        chk("f_w0_daok", 32'(data_addr_ok_out), 0);
        chk("f_w0_idok", 32'(inst_data_ok_out), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("f_w1_daok", 32'(data_addr_ok_out), 0);
        @(posedge clk); #1;
        bus_data_ok_in = 1'b1;
        bus_rdata_in   = 32'h1357_9BDF;
        @(negedge clk);
        chk("f_idok", 32'(inst_data_ok_out), 1);
        chk("f_ird", inst_rdata_out, 32'h1357_9BDF);
        chk("f_drd", data_rdata_out, 0);
        chk("f_ddok", 32'(data_data_ok_out), 0);
        chk("f_daok_done", 32'(data_addr_ok_out), 0);
        @(posedge clk); #1;
        bus_data_ok_in = 1'b0;
        @(negedge clk);
        chk("f_daok_next", 32'(data_addr_ok_out), 1);

        // Reset while WAIT, then a stray data_ok
        @(posedge clk); #1;
        data_req_in = 1'b0;
        @(negedge clk);
        chk("r_breq", 32'(bus_req_out), 1);
        chk("r_badr", bus_addr_out, 32'h300);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_wait_breq", 32'(bus_req_out), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("r_after");
        @(posedge clk); #1;
        bus_data_ok_in = 1'b1;
        @(negedge clk);
        chk("r_late_ddok", 32'(data_data_ok_out), 0);
        chk("r_late_idok", 32'(inst_data_ok_out), 0);
        chk("r_late_drd", data_rdata_out, 0);
        @(posedge clk); #1;
        bus_data_ok_in = 1'b0;
        data_req_in    = 1'b1;
        @(negedge clk);
        chk("r_idle_daok", 32'(data_addr_ok_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
